// File: rtl/adc_serial_capture.sv
// Serial capture front end for an AD7476-class ADC: each rising edge of tick_in
// runs one CS/SCLK read frame and publishes the low DATA_W bits as a strobed sample.
module adc_serial_capture #(
    parameter int CLK_DIV    = 4,
    parameter int FRAME_BITS = 16,
    parameter int DATA_W     = 12
) (
    input  logic              clk_in,
    input  logic              Res,
    input  logic              tick_in,
    input  logic              adc_sdata,
    output logic              adc_cs_n,
    output logic              adc_sclk,
    output logic [DATA_W-1:0] sample,
    output logic              sample_valid,
    output logic              busy,
    output logic              overrun
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD} state_t;

    state_t                  state;
    logic                    tick_d;
    logic                    trig;
    logic                    div_end;
    logic                    phase_hi;
    logic [DIV_W-1:0]        div_cnt;
    logic [BIT_W-1:0]        bit_cnt;
    logic [FRAME_BITS-1:0]   shift_reg;

    assign trig    = tick_in & ~tick_d;
    assign div_end = (div_cnt == DIV_LAST);

    always_ff @(posedge clk_in or posedge Res) begin
        if (Res) begin
            state        <= S_IDLE;
            tick_d       <= 1'b1;
            adc_cs_n     <= 1'b1;
            adc_sclk     <= 1'b1;
            sample       <= '0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
            phase_hi     <= 1'b0;
            div_cnt      <= '0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
        end else begin
            tick_d       <= tick_in;
            sample_valid <= 1'b0;
            // Triggers arriving mid-frame (HOLD exit cycle included) are dropped.
            if (trig && state != S_IDLE) begin
                overrun <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (trig) begin
                        state    <= S_SETUP;
                        adc_cs_n <= 1'b0;
                        busy     <= 1'b1;
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                        phase_hi <= 1'b0;
                    end
                end
                S_SETUP: begin
                    if (div_end) begin
                        div_cnt  <= '0;
                        state    <= S_SHIFT;
                        adc_sclk <= 1'b0;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        if (!phase_hi) begin
                            // Data is taken on the same edge that drives SCLK high.
                            adc_sclk  <= 1'b1;
                            phase_hi  <= 1'b1;
                            shift_reg <= {shift_reg[FRAME_BITS-2:0], adc_sdata};
                        end else if (bit_cnt == BIT_LAST) begin
                            state    <= S_HOLD;
                            adc_cs_n <= 1'b1;
                        end else begin
                            adc_sclk <= 1'b0;
                            phase_hi <= 1'b0;
                            bit_cnt  <= bit_cnt + 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (div_end) begin
                        div_cnt      <= '0;
                        state        <= S_IDLE;
                        busy         <= 1'b0;
                        sample       <= shift_reg[DATA_W-1:0];
                        sample_valid <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
